// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: word type, round constants,
// RotWord and the expander FSM state encoding.
package aes_pkg;

   localparam int NR_FIXED = 10;

   typedef logic [31:0] word_t;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_EMIT = 1'b1;

   localparam logic [7:0] RCON [1:10] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

   // Out-of-range round numbers yield zero so the unused path for round 11 stays defined.
   function automatic logic [7:0] rcon_of(input logic [3:0] r);
      if (r >= 4'd1 && r <= 4'd10) return RCON[r];
      return 8'h00;
   endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: byte-wise S-box substitution of one 32-bit word.
module aes_subword
   import aes_pkg::*;
(
   input  word_t w,
   output word_t y
);

   sbox u_sbox3 (.a(w[31:24]), .y(y[31:24]));
   sbox u_sbox2 (.a(w[23:16]), .y(y[23:16]));
   sbox u_sbox1 (.a(w[15:8]),  .y(y[15:8]));
   sbox u_sbox0 (.a(w[7:0]),   .y(y[7:0]));

endmodule

// File: rtl/sbox.sv
// AES forward S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] p;
      logic [7:0] m;
      p = '0;
      m = x;
      for (int i = 0; i < 8; i++) begin
         if (z[i]) p = p ^ m;
         m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Inverse computed as a^254 through a short square-and-multiply chain; 0 maps to 0.
   logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

   assign x2   = gf_mul(a, a);
   assign x3   = gf_mul(x2, a);
   assign x6   = gf_mul(x3, x3);
   assign x12  = gf_mul(x6, x6);
   assign x15  = gf_mul(x12, x3);
   assign x30  = gf_mul(x15, x15);
   assign x60  = gf_mul(x30, x30);
   assign x120 = gf_mul(x60, x60);
   assign x240 = gf_mul(x120, x120);
   assign x252 = gf_mul(x240, x12);
   assign inv  = gf_mul(x252, x2);

   assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes128_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..10 over a valid/ready
// stream, one key per accepted handshake, then pulses done.
module aes128_key_expand
   import aes_pkg::*;
#(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk,
   output logic [3:0]   rk_idx,
   output logic         done,
   output logic [0:0]   fsm_state
);

   if (NR != NR_FIXED) begin : g_nr_check
      $error("aes128_key_expand supports only NR = 10");
   end

   // Handshake: rk/rk_idx are offered while rk_valid is high and are consumed on
   // any clock edge where rk_valid && rk_ready; they hold stable otherwise.
   logic [0:0] state;
   word_t      w0, w1, w2, w3;
   word_t      rot, sub, t;
   word_t      n0, n1, n2, n3;
   logic [3:0] r_next;

   assign {w0, w1, w2, w3} = rk;
   assign rot    = rot_word(w3);
   assign r_next = rk_idx + 4'd1;

   aes_subword u_subword (.w(rot), .y(sub));

   assign t  = sub ^ {rcon_of(r_next), 24'h0};
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign fsm_state = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         rk       <= '0;
         rk_idx   <= '0;
         rk_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  rk       <= key_in;
                  rk_idx   <= '0;
                  rk_valid <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               // rk_valid is always high in this state, so rk_ready alone completes a handshake.
               if (rk_ready) begin
                  if (rk_idx == 4'(NR)) begin
                     rk_valid <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     state    <= ST_IDLE;
                  end else begin
                     rk     <= {n0, n1, n2, n3};
                     rk_idx <= r_next;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_key_expand.sv
// Bench for aes128_key_expand: FIPS-197 style reference model, scoreboard of
// expected round keys, directed and randomized handshake scenarios.
module tb_aes128_key_expand;

   logic         clk, rst, start, busy, rk_valid, rk_ready, done;
   logic [127:0] key_in, rk;
   logic [3:0]   rk_idx;
   logic [0:0]   fsm_state;

   aes128_key_expand dut (
      .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy),
      .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk), .rk_idx(rk_idx),
      .done(done), .fsm_state(fsm_state)
   );

   localparam logic [127:0] A1_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] A1_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] A1_R2   = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] A1_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] ZERO_R1 = 128'h62636363626363636263636362636363;
   localparam logic [127:0] ZERO_R10= 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0] sb [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      logic [7:0] aa;
      logic [7:0] bb;
      r = 0; aa = a; bb = b;
      while (bb != 0) begin
         if (bb[0]) r = r ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return r;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, s;
      logic [7:0] c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 0;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sb[x] = s;
      end
   endtask

   function automatic logic [127:0] model_rk(input logic [127:0] key, input int r);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 4*r + 4; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   // ---------------- scoreboard ----------------
   logic [127:0] exp_q [$];
   bit           model_busy = 0;
   bit           done_due   = 0;
   bit           prev_stall = 0;
   bit           accepting;
   int           exp_idx    = 0;
   logic [127:0] cur_key    = '0;
   logic [127:0] prev_rk, exp_rk;
   logic [3:0]   prev_idx;

   always @(negedge clk) begin
      if (rst) begin
         model_busy = 0;
         done_due   = 0;
         prev_stall = 0;
         exp_q.delete();
      end else begin
         if (prev_stall) begin
            check("stall_rk", rk, prev_rk);
            check("stall_idx", 128'(rk_idx), 128'(prev_idx));
            check("stall_valid", 128'(rk_valid), 128'(1));
         end
         prev_stall = rk_valid && !rk_ready;
         prev_rk    = rk;
         prev_idx   = rk_idx;
         if (done || done_due) check("done_pulse", 128'(done), 128'(done_due));
         done_due  = 0;
         accepting = !model_busy && start;
         if (rk_valid && rk_ready) begin
            if (exp_q.size() == 0) begin
               check("hs_unexpected", 128'(rk_valid), 128'(0));
            end else begin
               exp_rk = exp_q.pop_front();
               check("rk", rk, exp_rk);
               check("rk_idx", 128'(rk_idx), 128'(exp_idx));
               if (cur_key == A1_KEY) begin
                  if (exp_idx == 1)  check("a1_idx1", rk, A1_R1);
                  if (exp_idx == 2)  check("a1_idx2", rk, A1_R2);
                  if (exp_idx == 10) check("a1_idx10", rk, A1_R10);
               end
               if (cur_key == '0) begin
                  if (exp_idx == 1)  check("zero_idx1", rk, ZERO_R1);
                  if (exp_idx == 10) check("zero_idx10", rk, ZERO_R10);
               end
               if (exp_idx == 10) begin
                  model_busy = 0;
                  done_due   = 1;
               end
               exp_idx++;
            end
         end
         if (accepting) begin
            for (int r = 0; r <= 10; r++) exp_q.push_back(model_rk(key_in, r));
            model_busy = 1;
            exp_idx    = 0;
            cur_key    = key_in;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] rand_key();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, 128'(rk_valid), 128'(0));
      check({tag, "_busy"},  128'(busy), 128'(0));
      check({tag, "_done"},  128'(done), 128'(0));
      check({tag, "_rk"},    rk, 128'(0));
      check({tag, "_idx"},   128'(rk_idx), 128'(0));
   endtask

   task automatic run_full(input logic [127:0] key);
      rk_ready = 1;
      key_in   = key;
      start    = 1;
      step();
      start  = 0;
      key_in = rand_key();
      for (int k = 0; k <= 10; k++) begin
         check("seq_valid", 128'(rk_valid), 128'(1));
         check("seq_idx", 128'(rk_idx), 128'(k));
         check("seq_busy", 128'(busy), 128'(1));
         step();
      end
      check("done_after_10", 128'(done), 128'(1));
      check("end_valid", 128'(rk_valid), 128'(0));
      check("end_busy", 128'(busy), 128'(0));
      check("hold_idx", 128'(rk_idx), 128'(10));
      check("hold_rk", rk, model_rk(key, 10));
      step();
      check("done_one_cycle", 128'(done), 128'(0));
   endtask

   task automatic wait_idx(input int n);
      for (int c = 0; c < 60; c++) begin
         if (rk_valid && rk_idx == 4'(n)) break;
         step();
      end
      check("wait_idx", {rk_valid, rk_idx}, {1'b1, 4'(n)});
   endtask

   task automatic wait_done(input int budget);
      for (int c = 0; c < budget; c++) begin
         if (done) break;
         step();
      end
      check("done_seen", 128'(done), 128'(1));
   endtask

   // ---------------- stimulus ----------------
   bit stalled;
   bit prev_done;

   initial begin
      rst = 1; start = 0; key_in = '0; rk_ready = 0;
      build_sbox();
      repeat (3) step();
      check_zero("reset");
      rst = 0;
      step();
      check_zero("post_reset");

      run_full(A1_KEY);
      run_full('0);
      repeat (3) run_full(rand_key());

      // Random backpressure with a long stall at round 5 and random start noise.
      key_in = A1_KEY; start = 1; rk_ready = 1'($urandom_range(0, 1));
      step();
      start = 0;
      stalled = 0;
      for (int c = 0; c < 400 && !done; c++) begin
         if (rk_valid && rk_idx == 4'd5 && !stalled) begin
            rk_ready = 0;
            repeat (20) step();
            check("stall20_idx", 128'(rk_idx), 128'(5));
            stalled = 1;
         end
         rk_ready = 1'($urandom_range(0, 1));
         key_in   = rand_key();
         start    = 1'($urandom_range(0, 1));
         step();
      end
      start = 0;
      check("bp_done", 128'(done), 128'(1));
      step();

      // start while busy must be ignored.
      rk_ready = 1; key_in = A1_KEY; start = 1;
      step();
      start = 0;
      wait_idx(3);
      start = 1; key_in = rand_key();
      step();
      start = 0;
      wait_done(20);
      step();

      // Asynchronous reset mid-expansion.
      key_in = A1_KEY; start = 1;
      step();
      start = 0;
      wait_idx(6);
      #2 rst = 1;
      #1 check_zero("async_rst");
      step();
      rst = 0;
      step();
      run_full('0);

      // start held high: each done cycle immediately accepts the next key.
      rk_ready = 1; start = 1; prev_done = 0;
      for (int c = 0; c < 40; c++) begin
         key_in = rand_key();
         step();
         if (prev_done) check("b2b_restart", {rk_valid, rk_idx}, {1'b1, 4'd0});
         if (done) check("b2b_done_busy", 128'(busy), 128'(0));
         prev_done = done;
      end
      start = 0;
      wait_done(20);
      step();
      step();
      check("queue_empty", 128'(exp_q.size()), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
